// File: rtl/ccff_chain_loader_if.sv
// Valid/ready word stream feeding the configuration chain loader.
interface ccff_chain_loader_if #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first onto the configuration chain head with a shift enable.
// Optional tail-stream CRC-16/CCITT signature: define CCFF_READBACK_CRC_EN.
module ccff_chain_loader #(
    parameter int unsigned  WORD_W    = 32,
    parameter int unsigned  CHAIN_LEN = 1024,
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic               prog_clk,
    input  logic               pReset_n,
    input  logic               start,
    ccff_chain_loader_if.slave s,
    output logic               ccff_head,
    output logic               ccff_clk_en,
    input  logic               ccff_tail,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   bits_left,
    output logic [15:0]        readback_crc
);
    localparam int unsigned WCNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FLUSH} state_t;

    state_t             state, state_nxt;
    logic [WORD_W-1:0]  word, word_nxt;
    logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
    logic [CNT_W-1:0]   bits_nxt;
    logic               head_nxt;
    logic               clk_en_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    assign s.s_ready = (state == FETCH);

    // State register and registered outputs
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state       <= IDLE;
            word        <= '0;
            wcnt        <= '0;
            bits_left   <= '0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            word        <= word_nxt;
            wcnt        <= wcnt_nxt;
            bits_left   <= bits_nxt;
            ccff_head   <= head_nxt;
            ccff_clk_en <= clk_en_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // Next-state and datapath; the final word only shifts its top bits_left bits
    always_comb begin
        state_nxt  = state;
        word_nxt   = word;
        wcnt_nxt   = wcnt;
        bits_nxt   = bits_left;
        head_nxt   = ccff_head;
        clk_en_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    bits_nxt  = CNT_W'(CHAIN_LEN);
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (s.s_valid) begin
                    word_nxt  = s.s_data;
                    wcnt_nxt  = (32'(bits_left) >= WORD_W) ? WCNT_W'(WORD_W)
                                                           : WCNT_W'(bits_left);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                head_nxt   = word[WORD_W-1];
                clk_en_nxt = 1'b1;
                word_nxt   = {word[WORD_W-2:0], 1'b0};
                bits_nxt   = bits_left - CNT_W'(1);
                wcnt_nxt   = wcnt - WCNT_W'(1);
                if (wcnt == WCNT_W'(1)) begin
                    state_nxt = (bits_left == CNT_W'(1)) ? FLUSH : FETCH;
                end
            end
            FLUSH: begin
                head_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Look ahead so busy/done line up with the FLUSH cycle itself
        busy_nxt = (state_nxt == FETCH) || (state_nxt == SHIFT);
        done_nxt = (state_nxt == FLUSH);
    end

`ifdef CCFF_READBACK_CRC_EN
    logic [15:0] crc, crc_nxt;
    logic        crc_fb;

    // CRC-16/CCITT over the old chain contents leaving the tail on every shift
    always_comb begin
        crc_nxt = crc;
        crc_fb  = crc[15] ^ ccff_tail;
        if ((state == IDLE) && start) begin
            crc_nxt = 16'hFFFF;
        end else if (ccff_clk_en) begin
            crc_nxt = {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            crc <= 16'hFFFF;
        end else begin
            crc <= crc_nxt;
        end
    end

    assign readback_crc = crc;
`else
    logic unused_tail;
    assign unused_tail  = ccff_tail;
    assign readback_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: 16-bit and 12-bit chains, 8-bit words.
module tb_ccff_chain_loader;
    localparam int unsigned WW = 8;
    localparam int unsigned LA = 16;
    localparam int unsigned LB = 12;

`ifdef CCFF_READBACK_CRC_EN
    localparam logic [15:0] CRC_RST = 16'hFFFF;
    localparam logic [15:0] CRC_EXP = 16'h0EC9;
`else
    localparam logic [15:0] CRC_RST = 16'h0000;
    localparam logic [15:0] CRC_EXP = 16'h0000;
`endif

    logic        prog_clk = 1'b0;
    logic        pReset_n = 1'b0;
    logic        start_a  = 1'b0;
    logic        start_b  = 1'b0;
    logic        ccff_head_a, ccff_clk_en_a, busy_a, done_a;
    logic        ccff_head_b, ccff_clk_en_b, busy_b, done_b;
    logic [4:0]  bits_left_a;
    logic [3:0]  bits_left_b;
    logic [15:0] crc_a, crc_b;
    logic [15:0] chain_a = 16'h1234;
    logic [11:0] chain_b = 12'h000;

    int total = 0;
    int bad   = 0;
    int shifts_a = 0, shifts_b = 0, dones_a = 0, dones_b = 0;
    logic [7:0] src_a[$];
    logic [7:0] src_b[$];
    logic       exp_a[$];
    logic       exp_b[$];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader_if #(.WORD_W(WW)) sa ();
    ccff_chain_loader_if #(.WORD_W(WW)) sb ();

    ccff_chain_loader #(.WORD_W(WW), .CHAIN_LEN(LA)) dut_a (
        .prog_clk     (prog_clk),
        .pReset_n     (pReset_n),
        .start        (start_a),
        .s            (sa),
        .ccff_head    (ccff_head_a),
        .ccff_clk_en  (ccff_clk_en_a),
        .ccff_tail    (chain_a[15]),
        .busy         (busy_a),
        .done         (done_a),
        .bits_left    (bits_left_a),
        .readback_crc (crc_a)
    );

    ccff_chain_loader #(.WORD_W(WW), .CHAIN_LEN(LB)) dut_b (
        .prog_clk     (prog_clk),
        .pReset_n     (pReset_n),
        .start        (start_b),
        .s            (sb),
        .ccff_head    (ccff_head_b),
        .ccff_clk_en  (ccff_clk_en_b),
        .ccff_tail    (chain_b[11]),
        .busy         (busy_b),
        .done         (done_b),
        .bits_left    (bits_left_b),
        .readback_crc (crc_b)
    );

    // Behavioural configuration chains shifted by the gated clock
    always @(posedge prog_clk) begin
        if (ccff_clk_en_a) chain_a <= {chain_a[14:0], ccff_head_a};
        if (ccff_clk_en_b) chain_b <= {chain_b[10:0], ccff_head_b};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] w, input int n);
        src_a.push_back(w);
        for (int i = 0; i < n; i++) exp_a.push_back(w[7-i]);
    endtask

    task automatic push_b(input logic [7:0] w, input int n);
        src_b.push_back(w);
        for (int i = 0; i < n; i++) exp_b.push_back(w[7-i]);
    endtask

    // Stream sources: present the queue head, pop on handshake
    initial begin
        sa.s_valid = 1'b0;
        sa.s_data  = 8'h00;
        forever begin
            @(posedge prog_clk);
            if (sa.s_valid && sa.s_ready && (src_a.size() > 0)) void'(src_a.pop_front());
            #1;
            sa.s_valid = (src_a.size() > 0);
            sa.s_data  = (src_a.size() > 0) ? src_a[0] : 8'h00;
        end
    end

    initial begin
        sb.s_valid = 1'b0;
        sb.s_data  = 8'h00;
        forever begin
            @(posedge prog_clk);
            if (sb.s_valid && sb.s_ready && (src_b.size() > 0)) void'(src_b.pop_front());
            #1;
            sb.s_valid = (src_b.size() > 0);
            sb.s_data  = (src_b.size() > 0) ? src_b[0] : 8'h00;
        end
    end

    // Monitors: every enabled shift must carry the next expected head bit
    always @(negedge prog_clk) begin
        if (pReset_n && ccff_clk_en_a) begin
            shifts_a++;
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head_a_extra: got bit %0b expected no shift", ccff_head_a);
            end else begin
                chk("head_a", 64'(ccff_head_a), 64'(exp_a.pop_front()));
            end
        end
        if (pReset_n && done_a) dones_a++;
    end

    always @(negedge prog_clk) begin
        if (pReset_n && ccff_clk_en_b) begin
            shifts_b++;
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head_b_extra: got bit %0b expected no shift", ccff_head_b);
            end else begin
                chk("head_b", 64'(ccff_head_b), 64'(exp_b.pop_front()));
            end
        end
        if (pReset_n && done_b) dones_b++;
    end

    // Start pulse at cycle 0, optional extra pulses; record per-cycle outputs of dut_a
    task automatic run_load(input int ncyc, input int x1, input int x2,
                            output logic [63:0] bv, output logic [63:0] dv,
                            output logic [63:0] ev, output logic [63:0] rv);
        bv = '0; dv = '0; ev = '0; rv = '0;
        @(negedge prog_clk);
        start_a = 1'b1;
        for (int k = 1; k < ncyc; k++) begin
            @(negedge prog_clk);
            bv[k] = busy_a;
            dv[k] = done_a;
            ev[k] = ccff_clk_en_a;
            rv[k] = sa.s_ready;
            start_a = (k == x1) || (k == x2);
        end
        start_a = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int lim);
        int   n = 0;
        logic d = 1'b0;
        while (!d && (n < lim)) begin
            @(negedge prog_clk);
            n++;
            d = sel ? done_b : done_a;
        end
        chk(sel ? "done_b_seen" : "done_a_seen", 64'(d), 64'(1));
        repeat (3) @(negedge prog_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bv, dv, ev, rv;
        int s0, d0;

        // Reset values
        #12;
        chk("rst_head",   64'(ccff_head_a),   64'(0));
        chk("rst_clk_en", 64'(ccff_clk_en_a), 64'(0));
        chk("rst_busy",   64'(busy_a),        64'(0));
        chk("rst_done",   64'(done_a),        64'(0));
        chk("rst_bits",   64'(bits_left_a),   64'(0));
        chk("rst_ready",  64'(sa.s_ready),    64'(0));
        chk("rst_crc",    64'(crc_a),         64'(CRC_RST));
        @(negedge prog_clk);
        pReset_n = 1'b1;

        // T1: A5,3C always valid; timing of busy/done/enable/ready
        push_a(8'hA5, 8);
        push_a(8'h3C, 8);
        s0 = shifts_a; d0 = dones_a;
        run_load(24, -1, -1, bv, dv, ev, rv);
        chk("t1_busy",   64'(bv[23:0]), 64'(24'h07FFFE));
        chk("t1_done",   64'(dv[23:0]), 64'(24'h080000));
        chk("t1_clk_en", 64'(ev[23:0]), 64'(24'h0FF7F8));
        chk("t1_ready",  64'(rv[23:0]), 64'(24'h000402));
        chk("t1_shifts", 64'(shifts_a - s0), 64'(16));
        chk("t1_dones",  64'(dones_a - d0),  64'(1));
        chk("t1_expq",   64'(exp_a.size()),  64'(0));
        chk("t1_chain",  64'(chain_a),       64'(16'hA53C));
        chk("t1_bits",   64'(bits_left_a),   64'(0));
        chk("t1_crc",    64'(crc_a),         64'(CRC_EXP));

        // T2: second word withheld for several cycles
        push_a(8'hC3, 8);
        s0 = shifts_a; d0 = dones_a;
        run_load(16, -1, -1, bv, dv, ev, rv);
        chk("t2_stall_en",    64'(ev[15:0]), 64'(16'h07F8));
        chk("t2_stall_ready", 64'(rv[15:0]), 64'(16'hFC02));
        push_a(8'h5A, 8);
        wait_done(1'b0, 40);
        chk("t2_shifts", 64'(shifts_a - s0), 64'(16));
        chk("t2_dones",  64'(dones_a - d0),  64'(1));
        chk("t2_chain",  64'(chain_a),       64'(16'hC35A));
        chk("t2_expq",   64'(exp_a.size()),  64'(0));

        // T3: reset asserted after the 7th shift, then a full reload
        push_a(8'hE7, 8);
        push_a(8'h18, 8);
        s0 = shifts_a;
        @(negedge prog_clk);
        start_a = 1'b1;
        @(negedge prog_clk);
        start_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (shifts_a - s0 >= 7) break;
            @(negedge prog_clk);
        end
        chk("t3_reach_bit7", 64'(shifts_a - s0), 64'(7));
        #1;
        pReset_n = 1'b0;
        #1;
        chk("t3_rst_head",   64'(ccff_head_a),   64'(0));
        chk("t3_rst_clk_en", 64'(ccff_clk_en_a), 64'(0));
        chk("t3_rst_busy",   64'(busy_a),        64'(0));
        chk("t3_rst_bits",   64'(bits_left_a),   64'(0));
        chk("t3_rst_ready",  64'(sa.s_ready),    64'(0));
        chk("t3_rst_crc",    64'(crc_a),         64'(CRC_RST));
        exp_a.delete();
        src_a.delete();
        @(negedge prog_clk);
        pReset_n = 1'b1;
        push_a(8'h96, 8);
        push_a(8'h0F, 8);
        s0 = shifts_a; d0 = dones_a;
        run_load(24, -1, -1, bv, dv, ev, rv);
        chk("t3_done",   64'(dv[23:0]),      64'(24'h080000));
        chk("t3_shifts", 64'(shifts_a - s0), 64'(16));
        chk("t3_dones",  64'(dones_a - d0),  64'(1));
        chk("t3_chain",  64'(chain_a),       64'(16'h960F));

        // T4: start pulsed during SHIFT and during FLUSH is ignored
        push_a(8'h0F, 8);
        push_a(8'hF0, 8);
        s0 = shifts_a; d0 = dones_a;
        run_load(40, 5, 19, bv, dv, ev, rv);
        chk("t4_busy",   64'(bv[39:0]), 64'(40'h00_0007_FFFE));
        chk("t4_done",   64'(dv[39:0]), 64'(40'h00_0008_0000));
        chk("t4_clk_en", 64'(ev[39:0]), 64'(40'h00_000F_F7F8));
        chk("t4_shifts", 64'(shifts_a - s0), 64'(16));
        chk("t4_dones",  64'(dones_a - d0),  64'(1));
        chk("t4_chain",  64'(chain_a),       64'(16'h0FF0));

        // T5: 12-bit chain, final word truncated to its top nibble
        push_b(8'hFF, 8);
        push_b(8'hA0, 4);
        @(negedge prog_clk);
        start_b = 1'b1;
        @(negedge prog_clk);
        start_b = 1'b0;
        chk("t5_bits_start", 64'(bits_left_b), 64'(12));
        wait_done(1'b1, 40);
        chk("t5_shifts", 64'(shifts_b),      64'(12));
        chk("t5_dones",  64'(dones_b),       64'(1));
        chk("t5_bits",   64'(bits_left_b),   64'(0));
        chk("t5_expq",   64'(exp_b.size()),  64'(0));
        chk("t5_srcq",   64'(src_b.size()),  64'(0));
        chk("t5_chain",  64'(chain_b),       64'(12'hFFA));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Upstream stage of the grid I/O configuration chain: takes decrypted bitstream words over a valid/ready stream and serializes them onto `ccff_head` of the first tile.
- Issues a shift-enable for the external prog_clk gate and tracks the exact chain length.
- Signals completion; optionally computes a CRC signature of the previous chain contents as they exit `ccff_tail`.

Parameters:
- WORD_W, 32, width of input bitstream words (>=2).
- CHAIN_LEN, 1024, total configuration flops in the chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived; do not override).

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a full chain load.
- s_data  input  WORD_W  bitstream word, MSB shifted first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  word accepted when s_valid && s_ready.
- ccff_head  output  1  serial data to chain head (registered).
- ccff_clk_en  output  1  chain shifts at the next prog_clk edge when 1 (registered); drives external ICG.
- ccff_tail  input  1  serial data returning from chain tail.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last bit is shifted.
- bits_left  output  CNT_W  remaining bits to shift.
- readback_crc  output  16  CRC of tail stream (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state IDLE; `s_ready`=0, `ccff_head`=0, `ccff_clk_en`=0, `busy`=0, `done`=0, `bits_left`=0, `readback_crc`=16'hFFFF, word shift register cleared.
- IDLE
  - On `start`=1: `bits_left`<=CHAIN_LEN, `busy`<=1, go to FETCH.
  - `start` while busy is ignored.
- FETCH
  - `s_ready`=1 combinationally in this state only; `ccff_clk_en`=0 (chain frozen while starved).
  - On a handshake: load the word, set the in-word counter to `min(WORD_W, bits_left)`, go to SHIFT.
  - No handshake: stay in FETCH indefinitely, no timeout.
- SHIFT (one bit per cycle)
  - Each cycle: `ccff_head`<=word MSB, `ccff_clk_en`<=1, word shifts left by 1, `bits_left` decrements by 1.
  - When the in-word counter reaches its last bit:
    - If `bits_left` becomes 0: go to FLUSH.
    - Otherwise: go to FETCH. This costs one idle bubble cycle with `ccff_clk_en`=0; there is no prefetch.
  - CHAIN_LEN not a multiple of WORD_W: the final word shifts only its top `bits_left` bits; its low bits are discarded.
- FLUSH
  - One cycle: `ccff_clk_en`<=0, `ccff_head`<=0, `done`<=1, `busy`<=0.
  - Next state is IDLE.
  - `done` lasts exactly one cycle.
- Throughput: CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) cycles minimum from start to done, plus upstream stall cycles.
- Chain clocking rule: the number of cycles with `ccff_clk_en`=1 per load is exactly CHAIN_LEN.
- `start` and the final FLUSH in the same cycle: the FLUSH completes, and that `start` is ignored.
- `pReset_n` asserted mid-load: immediate abort to the reset values; the partially shifted chain is left as-is, and the next `start` reloads from bit 0.
- `s_data` is ignored outside a handshake.

Optional Feature:
- Macro: CCFF_READBACK_CRC_EN.
- Enabled:
  - In every cycle where the registered `ccff_clk_en`=1, `ccff_tail` is sampled and folded into CRC-16/CCITT (poly 0x1021, MSB-first, init 0xFFFF).
  - The CRC is reinitialized to 0xFFFF on an accepted `start`.
  - `readback_crc` holds its final value from `done` until the next `start`, giving a signature of the prior configuration image for tamper checking.
- Disabled: `readback_crc` is tied to 16'h0000 and no CRC logic is synthesized.

Test Plan:
- WORD_W=8, CHAIN_LEN=16, words 0xA5,0x3C always valid, start -> `ccff_head` bits 1010010100111100 on the 16 `ccff_clk_en` cycles; one bubble between words; `done` pulses once at cycle 19 after start; `busy` is high for cycles 1-18.
- CHAIN_LEN=12, words 0xFF,0xA0 -> 12 shifts; last 4 bits 1010; 0x0 low nibble never driven; `bits_left` reaches 0.
- `s_valid` held low 5 cycles mid-load -> `ccff_clk_en`=0 throughout the stall; total `ccff_clk_en`-high count is still exactly CHAIN_LEN.
- `pReset_n` pulsed low at bit 7 of 16 -> all outputs go to reset values asynchronously; a new start reloads all 16 bits and `done` fires once.
- `start` pulsed during SHIFT and again in the FLUSH cycle -> both ignored; exactly one `done`.
- CCFF_READBACK_CRC_EN defined, model chain preloaded with 0x1234, CHAIN_LEN=16 -> `readback_crc` equals CRC-16/CCITT(0x1234)=0x0EC9 after `done`. Macro undefined -> `readback_crc`=0.
